// File: rtl/t5_fetch_if.sv
// t5_fetch_if: bundles the instruction-bus, redirect/stall and decode-facing
// signals of the tra5 fetch stage.
// Latency: none (wiring only). Backpressure: sstl from decode, iwb_ack from the bus slave.
//
// master : fetch stage (drives the iwb_* request, fpc/fins/fvld/sena/fmis)
// slave  : environment (bus slave + execute redirect + decode stall)
interface t5_fetch_if;
    // Wishbone classic instruction bus
    logic [31:0] iwb_adr;
    logic        iwb_stb;
    logic        iwb_cyc;
    logic [3:0]  iwb_sel;
    logic        iwb_we;
    logic        iwb_ack;
    logic [31:0] iwb_dat;

    // redirect from execute, stall from decode
    logic        xbra;
    logic [31:0] xtgt;
    logic        sstl;

    // queue head towards decode
    logic [31:0] fpc;
    logic [31:0] fins;
    logic        fvld;
    logic        sena;
    logic        fmis;

    modport master (
        output iwb_adr, iwb_stb, iwb_cyc, iwb_sel, iwb_we,
        input  iwb_ack, iwb_dat,
        input  xbra, xtgt, sstl,
        output fpc, fins, fvld, sena, fmis
    );

    modport slave (
        input  iwb_adr, iwb_stb, iwb_cyc, iwb_sel, iwb_we,
        output iwb_ack, iwb_dat,
        output xbra, xtgt, sstl,
        input  fpc, fins, fvld, sena, fmis
    );
endinterface

// File: rtl/t5_fetch.sv
// t5_fetch: RV32 instruction fetch stage, Wishbone classic reads into a 2-entry queue.
// Latency: word acked at edge N appears on fpc/fins/fvld after edge N; 1 instr/cycle with zero-wait ack.
// Backpressure: sstl freezes pops only; fetching continues until the queue holds 2, then stb drops.
//
// Ports:
//   sclk, srst      : clock, asynchronous active-high reset
//   bus (master)    : iwb_adr/stb/cyc/sel/we out, iwb_ack/dat in,
//                     xbra/xtgt redirect in, sstl stall in,
//                     fpc/fins/fvld/sena/fmis out to decode
// Optional feature (macro T5_FETCH_MISALIGN_EN): misaligned redirect targets raise a
// sticky fmis and halt fetching until an aligned redirect. Without it xtgt[1:0] is
// ignored and fmis is tied low.
module t5_fetch #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int          XLEN         = 32
) (
    input  logic       sclk,
    input  logic       srst,
    t5_fetch_if.master bus
);

    localparam logic [1:0] S_FETCH = 2'd0;
    localparam logic [1:0] S_WAIT  = 2'd1;
    localparam logic [1:0] S_FLUSH = 2'd2;

    localparam logic [XLEN-1:0] NOP_INS = 32'h0000_0013;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [1:0]      r_state;
    logic [XLEN-1:0] r_pc;          // address of the current/next bus request
    logic [XLEN-1:0] r_tgt;         // redirect target held while a stale cycle drains
    logic [1:0]      r_cnt;         // queue occupancy 0..2
    logic [XLEN-1:0] r_q_pc  [0:1]; // entry 0 is always the head
    logic [XLEN-1:0] r_q_ins [0:1];

    // ------------------------------------------------------------------
    // Combinational
    // ------------------------------------------------------------------
    logic [XLEN-1:0] w_tgt;
    logic            w_misal;
    logic            w_fmis;
    logic            w_fmis_nxt;
    logic            w_stb;
    logic            w_fvld;
    logic            w_sena;
    logic            w_push;
    logic [1:0]      w_cnt_pop;
    logic [1:0]      w_cnt_nxt;
    logic            w_wr_idx;
    logic [1:0]      w_state_nxt;
    logic [XLEN-1:0] w_pc_nxt;
    logic [XLEN-1:0] w_tgt_nxt;

    // The low two target bits never reach the bus address.
    assign w_tgt = {bus.xtgt[31:2], 2'b00};

`ifdef T5_FETCH_MISALIGN_EN
    logic r_fmis;

    assign w_misal = |bus.xtgt[1:0];
    assign w_fmis  = r_fmis;

    always_ff @(posedge sclk or posedge srst) begin
        if (srst) begin
            r_fmis <= 1'b0;
        end else begin
            r_fmis <= w_fmis_nxt;
        end
    end
`else
    logic w_unused_xtgt_lsb;

    assign w_misal           = 1'b0;
    assign w_fmis            = 1'b0;
    assign w_unused_xtgt_lsb = ^bus.xtgt[1:0];
`endif

    // Strobe is gated by srst so it drops the moment reset asserts, even
    // mid-cycle. A pending misalign fault suppresses new cycles but a FLUSH
    // still runs to completion so the slave sees a well-formed cycle.
    assign w_stb = ~srst & ((r_state == S_FLUSH) |
                            ((r_state == S_FETCH) & ~w_fmis));

    assign w_fvld = (r_cnt != 2'd0);

    // Redirect wins over stall and over any push: the head is about to be
    // thrown away, so decode must not consume it.
    assign w_sena = w_fvld & ~bus.sstl & ~bus.xbra;

    // Only a FETCH-state ack carries a word worth keeping.
    assign w_push = (r_state == S_FETCH) & w_stb & bus.iwb_ack & ~bus.xbra;

    assign w_cnt_pop = r_cnt - {1'b0, w_sena};
    assign w_cnt_nxt = w_cnt_pop + {1'b0, w_push};

    // Push lands behind whatever survives this cycle's pop. A push never
    // happens at count 2, so the slot index fits in one bit.
    assign w_wr_idx = w_cnt_pop[0];

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_tgt_nxt   = r_tgt;
        w_fmis_nxt  = w_fmis;

        if (bus.xbra) begin
            w_fmis_nxt = w_misal;
            if (w_stb && !bus.iwb_ack) begin
                // A cycle is still open on the bus: finish it, discard its
                // data, and only then start at the new target. A repeated
                // redirect here simply overwrites the held target.
                w_state_nxt = S_FLUSH;
                w_tgt_nxt   = w_tgt;
            end else begin
                // No open cycle (or it completes right now and is dropped).
                w_state_nxt = S_FETCH;
                w_pc_nxt    = w_tgt;
            end
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (w_push) begin
                        w_pc_nxt = r_pc + 32'd4;
                        if (w_cnt_nxt == 2'd2) begin
                            w_state_nxt = S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (w_sena) begin
                        w_state_nxt = S_FETCH;
                    end
                end
                S_FLUSH: begin
                    if (bus.iwb_ack) begin
                        w_state_nxt = S_FETCH;
                        w_pc_nxt    = r_tgt;
                    end
                end
                default: begin
                    w_state_nxt = S_FETCH;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge sclk or posedge srst) begin
        if (srst) begin
            r_state    <= S_FETCH;
            r_pc       <= RESET_VECTOR;
            r_tgt      <= RESET_VECTOR;
            r_cnt      <= 2'd0;
            r_q_pc[0]  <= '0;
            r_q_pc[1]  <= '0;
            r_q_ins[0] <= NOP_INS;
            r_q_ins[1] <= NOP_INS;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_tgt   <= w_tgt_nxt;

            if (bus.xbra) begin
                // Entry contents are left as-is; with count 0 they are
                // invisible because fvld and sena are both low.
                r_cnt <= 2'd0;
            end else begin
                r_cnt <= w_cnt_nxt;
                if (w_sena) begin
                    r_q_pc[0]  <= r_q_pc[1];
                    r_q_ins[0] <= r_q_ins[1];
                end
                // Placed after the shift so a push into slot 0 on a
                // push+pop cycle overrides the shifted value.
                if (w_push) begin
                    r_q_pc[w_wr_idx]  <= r_pc;
                    r_q_ins[w_wr_idx] <= bus.iwb_dat;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.iwb_adr = r_pc;
    assign bus.iwb_stb = w_stb;
    assign bus.iwb_cyc = w_stb;
    assign bus.iwb_sel = 4'hF;
    assign bus.iwb_we  = 1'b0;

    assign bus.fpc  = r_q_pc[0];
    assign bus.fins = r_q_ins[0];
    assign bus.fvld = w_fvld;
    assign bus.sena = w_sena;
    assign bus.fmis = w_fmis;

endmodule

// File: tb/tb_t5_fetch.sv
// tb_t5_fetch: directed bench for the t5_fetch stage.
// Memory image: the word at address A is ~A.
module tb_t5_fetch;

    localparam logic [31:0] RV = 32'h8000_0000;

    logic sclk = 1'b0;
    logic srst;
    logic zw;       // 1: slave acks in the same cycle as stb
    logic ack_man;  // manual ack when zw = 0

    int checks = 0;
    int errors = 0;

    t5_fetch_if bus ();

    t5_fetch #(
        .RESET_VECTOR (RV),
        .XLEN         (32)
    ) dut (
        .sclk (sclk),
        .srst (srst),
        .bus  (bus)
    );

    always #5 sclk = ~sclk;

    assign bus.iwb_ack = zw ? bus.iwb_stb : ack_man;
    assign bus.iwb_dat = ~bus.iwb_adr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge sclk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        srst     = 1'b1;
        zw       = 1'b0;
        ack_man  = 1'b0;
        bus.xbra = 1'b0;
        bus.xtgt = 32'h0;
        bus.sstl = 1'b0;

        // ---------------- reset state ----------------
        tick();
        chk("rst_stb",  {31'h0, bus.iwb_stb}, 32'h0);
        chk("rst_cyc",  {31'h0, bus.iwb_cyc}, 32'h0);
        chk("rst_adr",  bus.iwb_adr, RV);
        chk("rst_fvld", {31'h0, bus.fvld}, 32'h0);
        chk("rst_sena", {31'h0, bus.sena}, 32'h0);
        chk("rst_fmis", {31'h0, bus.fmis}, 32'h0);
        chk("rst_fpc",  bus.fpc, 32'h0);
        chk("rst_fins", bus.fins, 32'h0000_0013);
        chk("rst_sel",  {28'h0, bus.iwb_sel}, 32'hF);
        chk("rst_we",   {31'h0, bus.iwb_we}, 32'h0);

        // ---------------- zero-wait streaming ----------------
        srst = 1'b0;
        zw   = 1'b1;
        settle();
        chk("st0_stb",  {31'h0, bus.iwb_stb}, 32'h1);
        chk("st0_adr",  bus.iwb_adr, RV);
        chk("st0_fvld", {31'h0, bus.fvld}, 32'h0);
        for (int k = 1; k <= 6; k++) begin
            tick();
            chk("st_fvld", {31'h0, bus.fvld}, 32'h1);
            chk("st_fpc",  bus.fpc, RV + 32'(4 * (k - 1)));
            chk("st_fins", bus.fins, ~(RV + 32'(4 * (k - 1))));
            chk("st_adr",  bus.iwb_adr, RV + 32'(4 * k));
            chk("st_sena", {31'h0, bus.sena}, 32'h1);
        end

        // ---------------- stall: queue fills to 2 then stb drops ----------------
        bus.sstl = 1'b1;
        settle();
        chk("stl_sena", {31'h0, bus.sena}, 32'h0);
        for (int c = 0; c < 5; c++) begin
            tick();
            chk("stl_stb",  {31'h0, bus.iwb_stb}, 32'h0);
            chk("stl_fvld", {31'h0, bus.fvld}, 32'h1);
            chk("stl_fpc",  bus.fpc, RV + 32'd20);
        end
        bus.sstl = 1'b0;
        settle();
        chk("rel_sena", {31'h0, bus.sena}, 32'h1);
        tick();
        chk("rel_fpc1", bus.fpc, RV + 32'd24);
        chk("rel_stb",  {31'h0, bus.iwb_stb}, 32'h1);
        chk("rel_adr",  bus.iwb_adr, RV + 32'd28);
        tick();
        chk("rel_fpc2", bus.fpc, RV + 32'd28);
        chk("rel_adr2", bus.iwb_adr, RV + 32'd32);

        // ---------------- redirect into FLUSH with a slow slave ----------------
        zw      = 1'b0;
        ack_man = 1'b0;
        tick();
        chk("fl_pre_fvld", {31'h0, bus.fvld}, 32'h0);
        chk("fl_pre_adr",  bus.iwb_adr, RV + 32'd32);
        bus.xbra = 1'b1;
        bus.xtgt = 32'h0000_0100;
        settle();
        chk("fl_sena", {31'h0, bus.sena}, 32'h0);
        tick();
        bus.xbra = 1'b0;
        chk("fl_stb1", {31'h0, bus.iwb_stb}, 32'h1);
        chk("fl_adr1", bus.iwb_adr, RV + 32'd32);
        tick();
        chk("fl_adr2", bus.iwb_adr, RV + 32'd32);
        ack_man = 1'b1;
        settle();
        tick();
        ack_man = 1'b0;
        chk("fl_drop_fvld", {31'h0, bus.fvld}, 32'h0);
        chk("fl_new_adr",   bus.iwb_adr, 32'h0000_0100);
        chk("fl_new_stb",   {31'h0, bus.iwb_stb}, 32'h1);
        zw = 1'b1;
        tick();
        chk("fl_first_fvld", {31'h0, bus.fvld}, 32'h1);
        chk("fl_first_fpc",  bus.fpc, 32'h0000_0100);
        chk("fl_first_fins", bus.fins, ~32'h0000_0100);
        chk("fl_first_adr",  bus.iwb_adr, 32'h0000_0104);

        // ---------------- redirect coincident with ack ----------------
        bus.xbra = 1'b1;
        bus.xtgt = 32'h0000_0040;
        settle();
        chk("co_sena", {31'h0, bus.sena}, 32'h0);
        tick();
        bus.xbra = 1'b0;
        bus.sstl = 1'b1;
        chk("co_fvld", {31'h0, bus.fvld}, 32'h0);
        chk("co_adr",  bus.iwb_adr, 32'h0000_0040);
        tick();
        chk("co_fill_fpc", bus.fpc, 32'h0000_0040);
        chk("co_fill_adr", bus.iwb_adr, 32'h0000_0044);
        tick();
        chk("full_stb", {31'h0, bus.iwb_stb}, 32'h0);
        chk("full_fpc", bus.fpc, 32'h0000_0040);

        // ---------------- redirect with a full queue (WAIT) ----------------
        bus.xbra = 1'b1;
        bus.xtgt = 32'h0000_0300;
        settle();
        chk("fq_sena", {31'h0, bus.sena}, 32'h0);
        tick();
        bus.xbra = 1'b0;
        bus.sstl = 1'b0;
        chk("fq_fvld", {31'h0, bus.fvld}, 32'h0);
        chk("fq_adr",  bus.iwb_adr, 32'h0000_0300);
        chk("fq_stb",  {31'h0, bus.iwb_stb}, 32'h1);

        // ---------------- PC wrap ----------------
        bus.xbra = 1'b1;
        bus.xtgt = 32'hFFFF_FFFC;
        settle();
        tick();
        bus.xbra = 1'b0;
        chk("wr_adr",  bus.iwb_adr, 32'hFFFF_FFFC);
        chk("wr_fvld", {31'h0, bus.fvld}, 32'h0);
        tick();
        chk("wr_fpc",  bus.fpc, 32'hFFFF_FFFC);
        chk("wr_fins", bus.fins, 32'h0000_0003);
        chk("wr_adr0", bus.iwb_adr, 32'h0000_0000);

        // ---------------- misaligned target ----------------
        bus.xbra = 1'b1;
        bus.xtgt = 32'h0000_0202;
        settle();
        tick();
        bus.xbra = 1'b0;
`ifdef T5_FETCH_MISALIGN_EN
        chk("mis_fmis", {31'h0, bus.fmis}, 32'h1);
        chk("mis_stb",  {31'h0, bus.iwb_stb}, 32'h0);
        chk("mis_fvld", {31'h0, bus.fvld}, 32'h0);
        tick();
        chk("mis_stb2",  {31'h0, bus.iwb_stb}, 32'h0);
        chk("mis_fmis2", {31'h0, bus.fmis}, 32'h1);
        chk("mis_fvld2", {31'h0, bus.fvld}, 32'h0);
`else
        chk("mis_fmis", {31'h0, bus.fmis}, 32'h0);
        chk("mis_adr",  bus.iwb_adr, 32'h0000_0200);
        chk("mis_stb",  {31'h0, bus.iwb_stb}, 32'h1);
        tick();
        chk("mis_fpc",  bus.fpc, 32'h0000_0200);
        chk("mis_adr2", bus.iwb_adr, 32'h0000_0204);
`endif
        bus.xbra = 1'b1;
        bus.xtgt = 32'h0000_0200;
        settle();
        tick();
        bus.xbra = 1'b0;
        chk("al_fmis", {31'h0, bus.fmis}, 32'h0);
        chk("al_adr",  bus.iwb_adr, 32'h0000_0200);
        chk("al_stb",  {31'h0, bus.iwb_stb}, 32'h1);
        chk("al_fvld", {31'h0, bus.fvld}, 32'h0);

        // ---------------- second redirect during FLUSH replaces target ----------------
        zw       = 1'b0;
        ack_man  = 1'b0;
        bus.xbra = 1'b1;
        bus.xtgt = 32'h0000_0500;
        settle();
        tick();
        chk("rp_adr1", bus.iwb_adr, 32'h0000_0200);
        chk("rp_stb1", {31'h0, bus.iwb_stb}, 32'h1);
        bus.xtgt = 32'h0000_0600;
        settle();
        tick();
        bus.xbra = 1'b0;
        chk("rp_adr2", bus.iwb_adr, 32'h0000_0200);
        ack_man = 1'b1;
        settle();
        tick();
        ack_man = 1'b0;
        chk("rp_adr3", bus.iwb_adr, 32'h0000_0600);
        chk("rp_fvld", {31'h0, bus.fvld}, 32'h0);
        chk("rp_stb3", {31'h0, bus.iwb_stb}, 32'h1);

        // ---------------- async reset mid bus cycle ----------------
        srst = 1'b1;
        settle();
        chk("ar_stb",  {31'h0, bus.iwb_stb}, 32'h0);
        chk("ar_cyc",  {31'h0, bus.iwb_cyc}, 32'h0);
        chk("ar_adr",  bus.iwb_adr, RV);
        chk("ar_fvld", {31'h0, bus.fvld}, 32'h0);
        chk("ar_fpc",  bus.fpc, 32'h0);
        chk("ar_fins", bus.fins, 32'h0000_0013);
        tick();
        srst = 1'b0;
        settle();
        chk("ar_rel_stb", {31'h0, bus.iwb_stb}, 32'h1);
        chk("ar_rel_adr", bus.iwb_adr, RV);
        zw = 1'b1;
        tick();
        chk("ar_fpc2",  bus.fpc, RV);
        chk("ar_fvld2", {31'h0, bus.fvld}, 32'h1);
        chk("ar_adr2",  bus.iwb_adr, RV + 32'd4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/t5_fetch.md
Name: t5_fetch

Overview:
- Instruction fetch stage of the tra5 RV32 pipeline, directly upstream of the decode stage.
- Issues Wishbone classic read cycles for sequential instruction addresses.
- Buffers returned words in a 2-entry instruction queue.
- Presents the queue head (fpc, fins) plus the decode advance strobe (sena); handles execute-stage redirects and downstream stalls.

Parameters:
- RESET_VECTOR, 32'h00000000, first fetch address after reset.
- XLEN, 32, datapath width; only 32 is supported.

Ports:
- sclk  in  1  system clock
- srst  in  1  reset, asynchronous, active-high
- iwb_adr  out  32  instruction bus address; bits [1:0] always 0
- iwb_stb  out  1  bus strobe
- iwb_cyc  out  1  bus cycle; equals iwb_stb
- iwb_sel  out  4  byte selects; constant 4'hF
- iwb_we  out  1  write enable; constant 0
- iwb_ack  in  1  bus acknowledge; may arrive in the same cycle as stb
- iwb_dat  in  32  instruction read data
- xbra  in  1  redirect request from execute (taken branch, jump, trap)
- xtgt  in  32  redirect target address
- sstl  in  1  downstream stall; decode must not advance
- fpc  out  32  PC of the queue head; feeds decode fpc
- fins  out  32  instruction at the queue head; feeds decode iwb_dat
- fvld  out  1  queue head valid
- sena  out  1  decode advance strobe; feeds decode sena
- fmis  out  1  misaligned-target fault (optional feature only)

Behaviour:
- Reset (asynchronous, any cycle, including mid-bus-cycle):
  - iwb_stb/iwb_cyc = 0, iwb_adr = RESET_VECTOR.
  - Queue count = 0; fvld = 0; sena = 0; fmis = 0.
  - fpc = 32'h0; fins = 32'h00000013 (NOP).
  - State = FETCH.
- Any bus cycle in progress at reset is abandoned.
- State machine: FETCH, WAIT, FLUSH.
  - FETCH: stb = 1, iwb_adr = pc.
    - On ack: push {pc, iwb_dat}; pc <= pc + 4 (wraps modulo 2^32).
    - If the count after push/pop is 2: go to WAIT. Otherwise stay in FETCH and issue the next address next cycle.
  - WAIT: stb = 0. Go to FETCH when the count drops below 2, i.e. on a cycle with a pop.
  - FLUSH: stb = 1, holding the stale address until ack. Ack data is discarded. Then go to FETCH with pc = the latched redirect target.
- Queue: 2-entry FIFO of {pc, instruction}.
  - Pop occurs when sena = 1.
  - Simultaneous push and pop keep the count unchanged.
  - Push never occurs at count 2 (guaranteed by WAIT).
- fvld = (count != 0). fpc and fins show the head entry and are registered from the queue.
- sena = fvld & ~sstl & ~xbra. sena is combinational from registered state and the inputs.
- Redirect (xbra = 1 for one cycle):
  - Queue cleared at the edge; pc <= {xtgt[31:2], 2'b00}.
  - If stb is high with no ack that cycle: go to FLUSH, and the target is latched.
  - If ack coincides with xbra: that data is dropped and the state goes to FETCH.
  - First post-redirect request is on the next cycle (or after the FLUSH ack).
  - xbra takes priority over sstl and over any push.
  - A second xbra while in FLUSH replaces the latched target.
- sstl: freezes pops only. Fetching continues until the queue is full.
- Throughput: 1 instruction/cycle when ack is returned in the same cycle as stb.
- Latency: a word acked at edge N is visible on fins/fvld after edge N.

Optional Feature:
- Macro: T5_FETCH_MISALIGN_EN.
- Defined:
  - xbra with xtgt[1:0] != 0 sets fmis = 1 (sticky), clears the queue, and stops fetching (stb = 0, no new cycles).
  - An outstanding cycle completes and its data is discarded.
  - Only reset, or an xbra with an aligned target, clears fmis and resumes fetching.
- Undefined: xtgt[1:0] ignored (forced to 00); fmis tied to 0.

Test Plan:
- Reset release, zero-wait slave (ack = stb): iwb_adr sequence 0x0, 0x4, 0x8, ...; fvld = 1 from second cycle; fpc/fins match memory each cycle with sena = 1.
- sstl held high 5 cycles from steady state: exactly 2 entries buffered, then stb = 0. On sstl release, fpc continues contiguously with no gap or duplicate.
- xbra with xtgt = 0x100 while the slave delays ack 3 cycles: FLUSH state, stale data dropped, next iwb_adr = 0x100, first fvld entry has fpc = 0x100.
- xbra coincident with ack and with a full queue: sena = 0 that cycle, count = 0 after the edge, no stale fpc ever reaches decode.
- Async srst asserted mid-cycle (stb = 1, no ack): stb drops immediately; after release, iwb_adr = RESET_VECTOR (test with RESET_VECTOR = 0x80000000).
- With T5_FETCH_MISALIGN_EN, xbra with xtgt = 0x202: fmis = 1, stb stays 0. A later xbra with xtgt = 0x200 clears fmis and iwb_adr = 0x200.
